// File: rtl/feistel_iter_cipher.sv
// Iterative Feistel block cipher core: one round per clock, serial key/data load.
// A start/busy/done handshake runs one operation. The decrypt input, sampled
// with start, selects encrypt or decrypt for that operation.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   in_bit      serial bit for the key or data register
//   shift_key   shift in_bit into the key register (wins over shift_data)
//   shift_data  shift in_bit into the data register
//   start       begin an operation on the current key/data (IDLE only)
//   decrypt     mode sampled with start: 0 = encrypt, 1 = decrypt
//   busy        rounds in progress
//   done        one-cycle pulse; dout is valid
//   dout        result {L,R}, held until the next done
//
// Optional build macro FEISTEL_CHAIN_EN adds a CBC-style chain register.
// Encrypt XORs the chain into the block input, and decrypt XORs it into the
// result. Any key shift clears the chain.
module feistel_iter_cipher #(
    parameter int unsigned HALF_W = 8,
    parameter int unsigned ROUNDS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_bit,
    input  logic                  shift_key,
    input  logic                  shift_data,
    input  logic                  start,
    input  logic                  decrypt,
    output logic                  busy,
    output logic                  done,
    output logic [2*HALF_W-1:0]   dout
);

    localparam int unsigned BLK_W = 2 * HALF_W;
    localparam int unsigned CNT_W = $clog2(ROUNDS);
    localparam logic [CNT_W-1:0] LAST_ENC = CNT_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BLK_W-1:0]     key_q, key_d;
    logic [BLK_W-1:0]     data_q, data_d;
    logic [HALF_W-1:0]    l_q, l_d;
    logic [HALF_W-1:0]    r_q, r_d;
    logic [CNT_W-1:0]     rnd_q, rnd_d;
    logic                 mode_q, mode_d;
    logic [BLK_W-1:0]     dout_d;
    logic                 busy_d, done_d;

    logic [HALF_W-1:0]    sub_k;
    logic [HALF_W-1:0]    l_rnd, r_rnd;
    logic                 last_rnd;
    logic [BLK_W-1:0]     blk_in;
    logic [BLK_W-1:0]     result;

`ifdef FEISTEL_CHAIN_EN
    logic [BLK_W-1:0]     chain_q, chain_d;
`endif

    function automatic logic [HALF_W-1:0] rotl1(input logic [HALF_W-1:0] x);
        return {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    // Single round datapath. Decrypt undoes the encrypt round with the same subkey.
    always_comb begin
        sub_k = (rnd_q[0] ? key_q[BLK_W-1:HALF_W] : key_q[HALF_W-1:0])
                ^ HALF_W'(rnd_q);
        l_rnd = r_q;
        r_rnd = l_q ^ (rotl1(r_q) ^ sub_k);
        if (mode_q) begin
            r_rnd = l_q;
            l_rnd = r_q ^ (rotl1(l_q) ^ sub_k);
        end
        // Encrypt counts up and decrypt counts down, so the last round index is mode dependent.
        last_rnd = mode_q ? (rnd_q == '0) : (rnd_q == LAST_ENC);
    end

    // Block input and final output. The chain XOR sides differ for encrypt and decrypt.
    always_comb begin
`ifdef FEISTEL_CHAIN_EN
        blk_in = decrypt ? data_q : (data_q ^ chain_q);
        result = mode_q ? ({l_rnd, r_rnd} ^ chain_q) : {l_rnd, r_rnd};
`else
        blk_in = data_q;
        result = {l_rnd, r_rnd};
`endif
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        data_d  = data_q;
        l_d     = l_q;
        r_d     = r_q;
        rnd_d   = rnd_q;
        mode_d  = mode_q;
        dout_d  = dout;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef FEISTEL_CHAIN_EN
        chain_d = chain_q;
`endif
        case (state_q)
            IDLE: begin
                if (shift_key) begin
                    key_d = {key_q[BLK_W-2:0], in_bit};
`ifdef FEISTEL_CHAIN_EN
                    chain_d = '0;
`endif
                end else if (shift_data) begin
                    data_d = {data_q[BLK_W-2:0], in_bit};
                end
                if (start) begin
                    mode_d  = decrypt;
                    l_d     = blk_in[BLK_W-1:HALF_W];
                    r_d     = blk_in[HALF_W-1:0];
                    rnd_d   = decrypt ? LAST_ENC : '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                l_d    = l_rnd;
                r_d    = r_rnd;
                if (last_rnd) begin
                    dout_d  = result;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef FEISTEL_CHAIN_EN
                    chain_d = mode_q ? data_q : result;
`endif
                end else begin
                    rnd_d = mode_q ? (rnd_q - CNT_W'(1)) : (rnd_q + CNT_W'(1));
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            data_q  <= '0;
            l_q     <= '0;
            r_q     <= '0;
            rnd_q   <= '0;
            mode_q  <= 1'b0;
            dout    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef FEISTEL_CHAIN_EN
            chain_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            data_q  <= data_d;
            l_q     <= l_d;
            r_q     <= r_d;
            rnd_q   <= rnd_d;
            mode_q  <= mode_d;
            dout    <= dout_d;
            busy    <= busy_d;
            done    <= done_d;
`ifdef FEISTEL_CHAIN_EN
            chain_q <= chain_d;
`endif
        end
    end

endmodule
